// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg: shared types and defaults for the Mini-SRC memory-path sequencer.
// Holds the sequencer state encoding, the latched-operation encoding, the
// default timeout limits and the request-priority helper.

package mem_seq_pkg;

    // Sequencer states; ERR is only reachable when MEM_TIMEOUT_EN is defined.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_MEM   = 3'd3,
        ST_LATCH = 3'd4,
        ST_XFER  = 3'd5,
        ST_DONE  = 3'd6,
        ST_ERR   = 3'd7
    } state_e;

    // Operation latched at accept time and held until DONE/ERR.
    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_FETCH = 2'd1,
        OP_LOAD  = 2'd2,
        OP_STORE = 2'd3
    } op_e;

    // Maximum MEM cycles without ack before giving up (timeout build only).
    localparam int DEF_TIMEOUT_CYCLES = 15;
    // Width of the wait counter; 2**DEF_CNT_W must exceed the limit.
    localparam int DEF_CNT_W          = 8;

    // Fixed request priority: fetch > load > store.
    function automatic op_e pick_op(input logic i_fetch, input logic i_load, input logic i_store);
        if (i_fetch) begin
            return OP_FETCH;
        end else if (i_load) begin
            return OP_LOAD;
        end else if (i_store) begin
            return OP_STORE;
        end
        return OP_NONE;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts MEM cycles spent waiting for mem_ack and flags the
// cycle in which the wait limit is hit without an ack. The counter is held at
// zero outside MEM, so it always starts from zero on MEM entry. Used by
// mem_seq_ctrl only when MEM_TIMEOUT_EN is defined.

module mem_wait_timer
    import mem_seq_pkg::*;
#(
    parameter int LIMIT = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic i_clock,
    input  logic i_clear,
    input  logic i_in_mem,
    input  logic i_mem_ack,
    output logic o_expired
);

    // r_cnt = number of MEM cycles already completed without ack, so the
    // current MEM cycle is the LIMIT-th one when r_cnt == LIMIT-1.
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] r_cnt;

    // Clear outside MEM, count each MEM cycle that ends without ack.
    always_ff @(posedge i_clock or negedge i_clear) begin
        if (!i_clear) begin
            r_cnt <= '0;
        end else if (!i_in_mem) begin
            r_cnt <= '0;
        end else if (!i_mem_ack) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // An ack on the limit cycle wins, so expiry requires mem_ack low.
    assign o_expired = i_in_mem && !i_mem_ack && (r_cnt == LIMIT_M1);

endmodule

// File: rtl/mem_seq_ctrl.sv
// mem_seq_ctrl: Mini-SRC memory-path control sequencer.
// Accepts fetch/load/store requests in IDLE (fetch > load > store), then walks
// ADDR -> [DATA] -> MEM -> [LATCH -> XFER] -> DONE, driving the PC/MAR/MDR/IR
// and destination-register enables and the memory read/write strobes.
// All outputs are decoded from registered state and the latched op only.
// Optional feature: define MEM_TIMEOUT_EN to bound the MEM wait to
// TIMEOUT_CYCLES cycles (ERR state, one-cycle err pulse); without it MEM waits
// for mem_ack indefinitely and err is constant 0.

module mem_seq_ctrl
    import mem_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic clock,
    input  logic clear,
    input  logic fetch_req,
    input  logic load_req,
    input  logic store_req,
    input  logic mem_ack,
    output logic busy,
    output logic done,
    output logic err,
    output logic pc_out,
    output logic inc_pc,
    output logic ea_out,
    output logic rb_out,
    output logic mar_in,
    output logic mdr_in,
    output logic mdr_read,
    output logic mdr_out,
    output logic ir_in,
    output logic rd_in,
    output logic mem_read,
    output logic mem_write
);

    // Elaboration-time guard on the timeout configuration.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255 || (1 << CNT_W) <= TIMEOUT_CYCLES) begin : g_bad_cfg
        $error("mem_seq_ctrl: TIMEOUT_CYCLES must be 1..255 and below 2**CNT_W");
    end

    state_e r_state;
    state_e w_next_state;
    op_e    r_op;
    op_e    w_next_op;
    op_e    w_req_op;
    logic   w_timeout;

    assign w_req_op = pick_op(fetch_req, load_req, store_req);

`ifdef MEM_TIMEOUT_EN
    logic w_in_mem;

    assign w_in_mem = (r_state == ST_MEM);

    mem_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES),
        .CNT_W (CNT_W)
    ) u_wait_timer (
        .i_clock   (clock),
        .i_clear   (clear),
        .i_in_mem  (w_in_mem),
        .i_mem_ack (mem_ack),
        .o_expired (w_timeout)
    );
`else
    // Without the timeout feature MEM only leaves on mem_ack.
    assign w_timeout = 1'b0;
`endif

    // State register: asynchronous clear returns to IDLE immediately.
    always_ff @(posedge clock or negedge clear) begin
        // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
        if (!clear) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Latched operation: captured on accept, dropped on DONE/ERR or clear.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_op <= OP_NONE;
        end else begin
            r_op <= w_next_op;
        end
    end

    // Next-state and next-op decode.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        w_next_state = r_state;
        w_next_op    = r_op;
        case (r_state)
            ST_IDLE: begin
                if (w_req_op != OP_NONE) begin
                    w_next_op    = w_req_op;
                    w_next_state = ST_ADDR;
                end
            end
            ST_ADDR: begin
                w_next_state = (r_op == OP_STORE) ? ST_DATA : ST_MEM;
            end
            ST_DATA: begin
                w_next_state = ST_MEM;
            end
            ST_MEM: begin
                if (mem_ack) begin
                    w_next_state = (r_op == OP_STORE) ? ST_DONE : ST_LATCH;
                end else if (w_timeout) begin
                    w_next_state = ST_ERR;
                end
            end
            ST_LATCH: begin
                w_next_state = ST_XFER;
            end
            ST_XFER: begin
                w_next_state = ST_DONE;
            end
            ST_DONE: begin
                w_next_op    = OP_NONE;
                w_next_state = ST_IDLE;
            end
            ST_ERR: begin
                w_next_op    = OP_NONE;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_op    = OP_NONE;
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Moore output decode from registered state and latched op.
    always_comb begin
        busy      = (r_state != ST_IDLE);
        done      = 1'b0;
        err       = 1'b0;
        pc_out    = 1'b0;
        inc_pc    = 1'b0;
        ea_out    = 1'b0;
        rb_out    = 1'b0;
        mar_in    = 1'b0;
        mdr_in    = 1'b0;
        mdr_read  = 1'b0;
        mdr_out   = 1'b0;
        ir_in     = 1'b0;
        rd_in     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        case (r_state)
            ST_ADDR: begin
                // MAR takes the old PC on the same edge PC increments.
                mar_in = 1'b1;
                if (r_op == OP_FETCH) begin
                    pc_out = 1'b1;
                    inc_pc = 1'b1;
                end else begin
                    ea_out = 1'b1;
                end
            end
            ST_DATA: begin
                // Store data enters MDR from the bus (mdr_read stays 0).
                rb_out = 1'b1;
                mdr_in = 1'b1;
            end
            ST_MEM: begin
                if (r_op == OP_STORE) begin
                    mem_write = 1'b1;
                end else begin
                    mem_read = 1'b1;
                end
            end
            ST_LATCH: begin
                mdr_in   = 1'b1;
                mdr_read = 1'b1;
            end
            ST_XFER: begin
                mdr_out = 1'b1;
                if (r_op == OP_FETCH) begin
                    ir_in = 1'b1;
                end else if (r_op == OP_LOAD) begin
                    rd_in = 1'b1;
                end
            end
            ST_DONE: begin
                done = 1'b1;
            end
            ST_ERR: begin
`ifdef MEM_TIMEOUT_EN
                err = 1'b1;
`endif
            end
            default: begin
            end
        endcase
    end

`ifndef SYNTHESIS
    // Only one source may drive the shared bus in any cycle.
    a_bus_exclusive: assert property (@(posedge clock) disable iff (!clear)
        $onehot0({pc_out, ea_out, rb_out, mdr_out}));

    // Read and write strobes are never raised together.
    a_strobe_exclusive: assert property (@(posedge clock) disable iff (!clear)
        !(mem_read && mem_write));
`endif

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// tb_mem_seq_ctrl: scoreboard bench for mem_seq_ctrl.
// Drivers issue operations and push the whole expected per-cycle output trace
// (derived from the operation type and the number of wait states the memory
// responder will insert) into a queue; a monitor pops one entry per cycle on
// the falling edge and compares it with the DUT outputs. An empty queue means
// the DUT must be idle with every output low.
// Honours MEM_TIMEOUT_EN (expects the err sequence) when defined.

module tb_mem_seq_ctrl;

    localparam int TO = 15;

    // Output vector bit positions.
    localparam int B_BUSY  = 14;
    localparam int B_DONE  = 13;
    localparam int B_ERR   = 12;
    localparam int B_PC    = 11;
    localparam int B_INC   = 10;
    localparam int B_EA    = 9;
    localparam int B_RB    = 8;
    localparam int B_MAR   = 7;
    localparam int B_MDRIN = 6;
    localparam int B_MDRRD = 5;
    localparam int B_MDROUT = 4;
    localparam int B_IR    = 3;
    localparam int B_RD    = 2;
    localparam int B_MRD   = 1;
    localparam int B_MWR   = 0;

    typedef logic [14:0] vec_t;
    typedef struct {
        vec_t  v;
        string tag;
    } exp_t;
    typedef enum int { K_FETCH = 0, K_LOAD = 1, K_STORE = 2 } kind_e;

    logic clock     = 1'b0;
    logic clear     = 1'b0;
    logic fetch_req = 1'b0;
    logic load_req  = 1'b0;
    logic store_req = 1'b0;
    logic mem_ack   = 1'b0;
    logic busy, done, err, pc_out, inc_pc, ea_out, rb_out, mar_in;
    logic mdr_in, mdr_read, mdr_out, ir_in, rd_in, mem_read, mem_write;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en   = 1'b1;
    int   ack_wait = 0;
    int   mem_cyc  = 0;

    mem_seq_ctrl dut (
        .clock     (clock),
        .clear     (clear),
        .fetch_req (fetch_req),
        .load_req  (load_req),
        .store_req (store_req),
        .mem_ack   (mem_ack),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .pc_out    (pc_out),
        .inc_pc    (inc_pc),
        .ea_out    (ea_out),
        .rb_out    (rb_out),
        .mar_in    (mar_in),
        .mdr_in    (mdr_in),
        .mdr_read  (mdr_read),
        .mdr_out   (mdr_out),
        .ir_in     (ir_in),
        .rd_in     (rd_in),
        .mem_read  (mem_read),
        .mem_write (mem_write)
    );

    always #5 clock = ~clock;

    function automatic vec_t sample();
        return {busy, done, err, pc_out, inc_pc, ea_out, rb_out, mar_in,
                mdr_in, mdr_read, mdr_out, ir_in, rd_in, mem_read, mem_write};
    endfunction

    function automatic void check(input string name, input vec_t act, input vec_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b (busy done err pc inc ea rb mar mdrin mdrrd mdrout ir rd mrd mwr)",
                     name, act, exp);
        end
    endfunction

    // Busy plus up to three other asserted bits.
    function automatic vec_t mk(input int a = -1, input int b = -1, input int c = -1);
        vec_t v = '0;
        v[B_BUSY] = 1'b1;
        if (a >= 0) v[a] = 1'b1;
        if (b >= 0) v[b] = 1'b1;
        if (c >= 0) v[c] = 1'b1;
        return v;
    endfunction

    function automatic void push(input vec_t v, input string tag);
        exp_t e;
        e.v   = v;
        e.tag = tag;
        exp_q.push_back(e);
    endfunction

    // Expected cycle-by-cycle outputs from the cycle after accept to DONE,
    // with w wait states (ack on MEM cycle w+1).
    function automatic void push_trace(input kind_e k, input int w);
        string n;
        n = (k == K_FETCH) ? "fetch" : (k == K_LOAD) ? "load" : "store";
        if (k == K_FETCH) push(mk(B_PC, B_MAR, B_INC), {n, ".addr"});
        else              push(mk(B_EA, B_MAR), {n, ".addr"});
        if (k == K_STORE) push(mk(B_RB, B_MDRIN), {n, ".data"});
        for (int i = 0; i <= w; i++) begin
            push(mk((k == K_STORE) ? B_MWR : B_MRD), {n, ".mem"});
        end
        if (k != K_STORE) begin
            push(mk(B_MDRIN, B_MDRRD), {n, ".latch"});
            push(mk(B_MDROUT, (k == K_FETCH) ? B_IR : B_RD), {n, ".xfer"});
        end
        push(mk(B_DONE), {n, ".done"});
    endfunction

    // Monitor: one expected entry per cycle; nothing queued means idle.
    always @(negedge clock) begin
        if (mon_en && clear) begin
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check(e.tag, sample(), e.v);
            end else begin
                check("idle", sample(), '0);
            end
        end
    end

    // Memory responder: ack on MEM cycle ack_wait+1, random noise outside MEM.
    always @(negedge clock) begin
        if (mem_read || mem_write) begin
            mem_cyc++;
            mem_ack = (mem_cyc == ack_wait + 1);
        end else begin
            mem_cyc = 0;
            mem_ack = 1'($urandom_range(0, 1));
        end
    end

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: cycle budget expired with %0d expected cycles pending, required 0",
                     name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run_op(input kind_e k, input int w, input bit stray);
        wait_drain("drain");
        @(negedge clock);
        #1;
        ack_wait = w;
        case (k)
            K_FETCH: begin
                fetch_req = 1'b1;
                load_req  = stray;
                store_req = stray & 1'($urandom_range(0, 1));
            end
            K_LOAD: begin
                load_req  = 1'b1;
                store_req = stray;
            end
            default: store_req = 1'b1;
        endcase
        push_trace(k, w);
        @(negedge clock);
        #1;
        fetch_req = 1'b0;
        load_req  = 1'b0;
        store_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        #2;
        check("reset.outputs", sample(), '0);
        repeat (3) @(negedge clock);
        #1;
        clear = 1'b1;

        // Directed: zero-wait fetch, 3-wait load, 2-wait store.
        run_op(K_FETCH, 0, 1'b0);
        run_op(K_LOAD, 3, 1'b0);
        run_op(K_STORE, 2, 1'b0);

        // Fetch and load on the same edge; load held and taken after DONE.
        wait_drain("drain");
        @(negedge clock);
        #1;
        ack_wait  = 1;
        fetch_req = 1'b1;
        load_req  = 1'b1;
        push_trace(K_FETCH, 1);
        push('0, "held.idle");
        push_trace(K_LOAD, 1);
        @(negedge clock);
        #1;
        fetch_req = 1'b0;
        repeat (1 + 5 + 1) @(negedge clock);
        #1;
        load_req = 1'b0;

        // Asynchronous clear while mem_read is high.
        wait_drain("drain");
        @(negedge clock);
        #1;
        ack_wait  = 50;
        fetch_req = 1'b1;
        push_trace(K_FETCH, 50);
        @(negedge clock);
        #1;
        fetch_req = 1'b0;
        @(negedge clock);
        #2;
        check("rst.pre_mem_read", {14'b0, mem_read}, 15'd1);
        clear  = 1'b0;
        mon_en = 1'b0;
        exp_q.delete();
        #1;
        check("rst.async", sample(), '0);
        @(posedge clock);
        #1;
        check("rst.hold", sample(), '0);
        @(negedge clock);
        #1;
        clear  = 1'b1;
        mon_en = 1'b1;
        run_op(K_FETCH, 0, 1'b0);

        // Randomized operations.
        for (int i = 0; i < 30; i++) begin
            run_op(kind_e'($urandom_range(0, 2)), int'($urandom_range(0, 4)),
                   1'($urandom_range(0, 1)));
        end

        // Memory never acknowledges.
        wait_drain("drain");
        @(negedge clock);
        #1;
        ack_wait = 100000;
        load_req = 1'b1;
`ifdef MEM_TIMEOUT_EN
        push(mk(B_EA, B_MAR), "timeout.addr");
        for (int i = 0; i < TO; i++) push(mk(B_MRD), "timeout.mem");
        push(mk(B_ERR), "timeout.err");
        @(negedge clock);
        #1;
        load_req = 1'b0;
        wait_drain("timeout");
`else
        mon_en = 1'b0;
        begin
            logic seen_end;
            seen_end = 1'b0;
            @(negedge clock);
            #1;
            load_req = 1'b0;
            repeat (40) begin
                @(negedge clock);
                seen_end = seen_end | done | err;
            end
            check("hang.busy", {14'b0, busy}, 15'd1);
            check("hang.mem_read", {14'b0, mem_read}, 15'd1);
            check("hang.no_done_err", {14'b0, seen_end}, 15'd0);
        end
        #1;
        clear = 1'b0;
        #1;
        check("hang.clear", sample(), '0);
        @(negedge clock);
        #1;
        clear  = 1'b1;
        mon_en = 1'b1;
`endif

        run_op(K_STORE, 0, 1'b0);
        wait_drain("final");
        repeat (3) @(negedge clock);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
